// File: rtl/workers_cpu_2_cpu_mul_seq.sv
// Multiply sequencer/combiner driving the 16x16 mult cell; builds the 32-bit low word,
// or the high word over a second pass when CPU_MULX_EN is defined.
module workers_cpu_2_cpu_mul_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3
);

`ifdef CPU_MULX_EN
    typedef enum logic [2:0] {IDLE, ISSUE_A, CAP_A, CAP_B, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE_A, CAP_A, DONE} state_t;
`endif

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic        accept;
    logic [17:0] s;
    logic [31:0] low;

    assign accept = start && (state == IDLE || state == DONE);
    assign s      = {2'b0, mul_p1[31:16]} + {2'b0, mul_p2[15:0]} + {2'b0, mul_p3[15:0]};
    assign low    = {s[15:0], mul_p1[15:0]};

`ifdef CPU_MULX_EN
    logic [31:0] a_q, b_q;
    logic [15:0] pa2_hi, pa3_hi;
    logic [1:0]  s_c;
    logic [31:0] hi_u, hi_c;
    logic        is_mulx;

    assign is_mulx = (op_q != 2'd0);
    assign hi_u    = mul_p1 + {16'h0, pa2_hi} + {16'h0, pa3_hi} + {30'h0, s_c};

    // Unsigned high word minus the two's-complement cross terms for signed operands.
    always_comb begin
        hi_c = hi_u;
        if (op_q[1] && a_q[31])
            hi_c = hi_c - b_q;
        if (op_q == 2'd3 && b_q[31])
            hi_c = hi_c - a_q;
    end
`else
    logic unused_bits;
    assign unused_bits = ^{op_q, mul_p2[31:16], mul_p3[31:16]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    state_nx = start ? ISSUE_A : IDLE;
            DONE: begin
                done     = 1'b1;
                state_nx = start ? ISSUE_A : IDLE;
            end
            ISSUE_A: begin
                busy     = 1'b1;
                state_nx = CAP_A;
            end
            CAP_A: begin
                busy     = 1'b1;
                state_nx = DONE;
`ifdef CPU_MULX_EN
                if (is_mulx)
                    state_nx = CAP_B;
`endif
            end
`ifdef CPU_MULX_EN
            CAP_B: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Cell inputs are registered so they are stable for the whole enabled cycle:
    // pass A is loaded on accept, pass B on leaving ISSUE_A so the cell samples it at end of CAP_A.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= 2'd0;
            result   <= 32'h0;
            mul_src1 <= 32'h0;
            mul_src2 <= 32'h0;
            mul_en   <= 1'b0;
`ifdef CPU_MULX_EN
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            pa2_hi   <= 16'h0;
            pa3_hi   <= 16'h0;
            s_c      <= 2'b0;
`endif
        end else begin
            mul_en <= 1'b0;
            if (accept) begin
                op_q     <= op;
                mul_src1 <= src1;
                mul_src2 <= src2;
                mul_en   <= 1'b1;
`ifdef CPU_MULX_EN
                a_q      <= src1;
                b_q      <= src2;
`endif
            end
`ifdef CPU_MULX_EN
            if (state == ISSUE_A && is_mulx) begin
                mul_src1 <= {16'h0, a_q[31:16]};
                mul_src2 <= {16'h0, b_q[31:16]};
                mul_en   <= 1'b1;
            end
            if (state == CAP_A) begin
                pa2_hi <= mul_p2[31:16];
                pa3_hi <= mul_p3[31:16];
                s_c    <= s[17:16];
                if (!is_mulx)
                    result <= low;
            end
            if (state == CAP_B)
                result <= hi_c;
`else
            if (state == CAP_A)
                result <= low;
`endif
        end
    end

endmodule

// File: tb/tb_workers_cpu_2_cpu_mul_seq.sv
// Self-checking bench for workers_cpu_2_cpu_mul_seq with a behavioural mult-cell model
// and a 64-bit arithmetic reference; adapts to whether CPU_MULX_EN is defined.
module tb_workers_cpu_2_cpu_mul_seq;

`ifdef CPU_MULX_EN
    localparam bit MULX = 1'b1;
`else
    localparam bit MULX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src1 = 32'h0, src2 = 32'h0;
    logic        busy, done, mul_en;
    logic [31:0] result, mul_src1, mul_src2;
    logic [31:0] mul_p1, mul_p2, mul_p3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    workers_cpu_2_cpu_mul_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src1(src1), .src2(src2), .busy(busy), .done(done), .result(result),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
        .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3)
    );

    // Mult cell: one registered enabled edge, async clear on the shared reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_p1 <= 32'h0;
            mul_p2 <= 32'h0;
            mul_p3 <= 32'h0;
        end else if (mul_en) begin
            mul_p1 <= {16'h0, mul_src1[15:0]}  * {16'h0, mul_src2[15:0]};
            mul_p2 <= {16'h0, mul_src1[15:0]}  * {16'h0, mul_src2[31:16]};
            mul_p3 <= {16'h0, mul_src1[31:16]} * {16'h0, mul_src2[15:0]};
        end
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if (!MULX || o == 2'd0) begin
            p = ea * eb;
            return p[31:0];
        end
        if (o[1])       ea = {{32{a[31]}}, a};
        if (o == 2'd3)  eb = {{32{b[31]}}, b};
        p = ea * eb;
        return p[63:32];
    endfunction

    function automatic int ref_lat(input logic [1:0] o);
        return (MULX && o != 2'd0) ? 4 : 3;
    endfunction

    // Issue one op; lat counts cycles after the accepting edge until done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noisy, output logic [31:0] res, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; bcnt = 0;
        forever begin
            if (done) begin
                start = 1'b0;
                break;
            end
            if (busy) bcnt++;
            if (lat >= 10) break;
            if (noisy) begin
                start = 1'($urandom); op = 2'($urandom); src1 = $urandom; src2 = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        res = result;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({busy, done, mul_en, result, mul_src1, mul_src2} !== 99'h0) begin
            $display("FAIL reset_state: busy=%0b done=%0b en=%0b result=%h s1=%h s2=%h, want all 0",
                     busy, done, mul_en, result, mul_src1, mul_src2);
        end else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [31:0] av  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000};
        logic [31:0] res, held;
        int lat, bcnt;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], av[i], av[i], 1'b0, res, lat, bcnt);
            n_total++;
            if (res !== ref_mul(ops[i], av[i], av[i]))
                $display("FAIL directed_result[%0d] op=%0d: got %h want %h", i, ops[i], res, ref_mul(ops[i], av[i], av[i]));
            else n_pass++;
            n_total++;
            if (lat !== ref_lat(ops[i]))
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, ref_lat(ops[i]));
            else n_pass++;
            n_total++;
            if (bcnt !== ref_lat(ops[i]) - 1)
                $display("FAIL directed_busy[%0d]: got %0d want %0d", i, bcnt, ref_lat(ops[i]) - 1);
            else n_pass++;
            held = res;
            @(posedge clk); #1;
            n_total++;
            if (done !== 1'b0 || result !== held)
                $display("FAIL directed_hold[%0d]: done=%0b result=%h want done=0 result=%h", i, done, result, held);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [31:0] corner [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [31:0] a, b, res;
        logic [1:0]  o;
        int lat, bcnt;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            run_op(o, a, b, 1'b1, res, lat, bcnt);
            n_total++;
            if (res !== ref_mul(o, a, b) || lat !== ref_lat(o))
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, o, a, b, res, lat, ref_mul(o, a, b), ref_lat(o));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 6;
        logic [31:0] a [N], b [N], exp_r [N];
        logic [1:0]  o [N];
        int idx = 0, lat, guard = 0;
        for (int i = 0; i < N; i++) begin
            o[i] = (i % 2 == 0) ? 2'd0 : 2'd3;
            a[i] = $urandom; b[i] = $urandom;
            exp_r[i] = ref_mul(o[i], a[i], b[i]);
        end
        @(negedge clk);
        start = 1'b1; op = o[0]; src1 = a[0]; src2 = b[0];
        @(posedge clk); #1;
        lat = 1;
        while (idx < N && guard < 200) begin
            if (done) begin
                n_total++;
                if (result !== exp_r[idx] || lat !== ref_lat(o[idx]))
                    $display("FAIL back_to_back[%0d]: got %h lat %0d want %h lat %0d",
                             idx, result, lat, exp_r[idx], ref_lat(o[idx]));
                else n_pass++;
                idx++;
                if (idx < N) begin
                    op = o[idx]; src1 = a[idx]; src2 = b[idx];
                end else start = 1'b0;
                lat = 0;
            end else begin
                op = 2'($urandom); src1 = $urandom; src2 = $urandom;
            end
            @(posedge clk); #1;
            lat++; guard++;
        end
        start = 1'b0;
        n_total++;
        if (idx !== N)
            $display("FAIL back_to_back_count: completed %0d want %0d", idx, N);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] res;
        int lat, bcnt;
        bit saw_done = 1'b0;
        run_op(2'd0, 32'h00001234, 32'h00005678, 1'b0, res, lat, bcnt);
        @(negedge clk);
        start = 1'b1; op = 2'd3; src1 = $urandom | 32'h80000000; src2 = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, mul_en, result, mul_src1, mul_src2} !== 99'h0)
            $display("FAIL reset_mid_op: busy=%0b done=%0b en=%0b result=%h s1=%h s2=%h, want all 0",
                     busy, done, mul_en, result, mul_src1, mul_src2);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_total++;
        if (saw_done !== 1'b0)
            $display("FAIL reset_no_done: done seen=%0b want 0", saw_done);
        else n_pass++;
        run_op(2'd0, 32'h3, 32'h5, 1'b0, res, lat, bcnt);
        n_total++;
        if (res !== 32'h0000000F || lat !== 3)
            $display("FAIL after_reset_mul: got %h lat %0d want 0000000f lat 3", res, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid_op;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
